ivl_uvm_mbx_arb: RTL and testbench

- Hardware message mailbox shared by NUM_REQ producers and drained by one consumer.
- Round-robin arbitration feeds one FIFO; multi-beat messages lock the grant so beats from different producers never interleave.
- Serves as the sequencing/arbitration front end for the mailbox resource used by the lightweight UVM environment's DUT-side message channels.

---
 rtl/ivl_uvm_mbx_arb.sv | 155 +++++++++++++++
 tb/tb_ivl_uvm_mbx_arb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ivl_uvm_mbx_arb.sv
// Mailbox front end: round-robin arbitration of NUM_REQ producers into one
// first-word-fall-through FIFO, with the grant locked for multi-beat messages.
module ivl_uvm_mbx_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = $clog2(DEPTH + 1),
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      get_valid,
    output logic [DATA_W-1:0]         get_data,
    input  logic                      get_ready,
    output logic                      grant_valid,
    output logic [ID_W-1:0]           grant_id,
    output logic                      lock_active,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              cand_valid;
    logic [ID_W-1:0]   cand_id;
    logic [ID_W-1:0]   scan_idx;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;
    logic              push_last;

    function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
        if (int'(id) == NUM_REQ - 1) return '0;
        return id + ID_W'(1);
    endfunction

    // Scan from the highest offset down so the last hit is the first requester at or after rr_ptr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cand_valid = 1'b0;
        cand_id    = '0;
        scan_idx   = '0;
        if (state_q == S_LOCKED) begin
            cand_valid = req_valid[owner_q];
            cand_id    = owner_q;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (req_valid[scan_idx]) begin
                    cand_valid = 1'b1;
                    cand_id    = scan_idx;
                end
            end
        end
    end

    assign grant_valid = cand_valid;
    assign grant_id    = cand_valid ? cand_id : '0;
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign push        = grant_valid & ~full;
    assign pop         = ~empty & get_ready;

    // Explicit mux so an unselected producer's data or last flag can never leak through.
    always_comb begin
        req_ready = '0;
        push_data = '0;
        push_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                req_ready[i] = grant_valid & ~full;
                push_data    = req_data[i*DATA_W +: DATA_W];
                push_last    = req_last[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (push) begin
            if (state_q == S_IDLE) begin
                if (push_last) begin
                    rr_ptr_d = inc_id(grant_id);
                end else begin
                    state_d = S_LOCKED;
                    owner_d = grant_id;
                end
            end else if (push_last) begin
                state_d  = S_IDLE;
                rr_ptr_d = inc_id(owner_q);
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; get_data is masked while empty, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign get_valid   = ~empty;
    assign get_data    = empty ? '0 : mem[rd_ptr_q];
    assign lock_active = (state_q == S_LOCKED);
    assign count       = count_q;

endmodule

// File: tb/tb_ivl_uvm_mbx_arb.sv
// Directed bench for ivl_uvm_mbx_arb: expected pops go into a scoreboard queue,
// a monitor compares every pop; the stimulus process checks arbitration and status.
module tb_ivl_uvm_mbx_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ID_W    = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      get_valid;
    logic [DATA_W-1:0]         get_data;
    logic                      get_ready;
    logic                      grant_valid;
    logic [ID_W-1:0]           grant_id;
    logic                      lock_active;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      empty;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] sb_q[$];

    ivl_uvm_mbx_arb #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .get_valid(get_valid), .get_data(get_data), .get_ready(get_ready),
        .grant_valid(grant_valid), .grant_id(grant_id), .lock_active(lock_active),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input int i, input logic v, input logic l, input logic [31:0] d);
        req_valid[i]               = v;
        req_last[i]                = l;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        sample();
        while (!empty && n < 40) begin
            next_cycle();
            sample();
            n++;
        end
        check(name, {63'd0, empty}, 64'd1);
        check({name, "_count"}, 64'(count), 64'd0);
    endtask

    // Monitor: every pop must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && get_valid && get_ready) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_unexpected_pop: got 0x%0h expected no pop", get_data);
                end else begin
                    check("sb_pop_data", 64'(get_data), 64'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        get_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Reset then idle
        sample();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_get_data", 64'(get_data), 64'd0);
        check("rst_get_valid", {63'd0, get_valid}, 64'd0);
        check("rst_lock", {63'd0, lock_active}, 64'd0);
        check("rst_grant_valid", {63'd0, grant_valid}, 64'd0);
        next_cycle();

        // Round-robin fairness: grant order 0,1,2,3,0
        sb_q.push_back(32'hA0); sb_q.push_back(32'hA1); sb_q.push_back(32'hA2);
        sb_q.push_back(32'hA3); sb_q.push_back(32'hA0);
        get_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) drive(i, 1'b1, 1'b1, 32'hA0 + 32'(i));
        for (int k = 0; k < 5; k++) begin
            sample();
            check("rr_grant_id", 64'(grant_id), 64'(k % 4));
            check("rr_req_ready", 64'(req_ready), 64'(1 << (k % 4)));
            if (k > 0) begin
                check("rr_get_valid", {63'd0, get_valid}, 64'd1);
                check("rr_count", 64'(count), 64'd1);
            end
            next_cycle();
        end
        req_valid = '0;
        sample();
        check("rr_tail_count", 64'(count), 64'd1);
        check("rr_tail_grant", {63'd0, grant_valid}, 64'd0);
        wait_empty("rr_drain");
        next_cycle();

        // Lock: producer 2 three-beat message with a gap, producer 3 waiting (rr_ptr=1)
        sb_q.push_back(32'h20); sb_q.push_back(32'h21);
        sb_q.push_back(32'h22); sb_q.push_back(32'h30);
        drive(2, 1'b1, 1'b0, 32'h20);
        drive(3, 1'b1, 1'b1, 32'h30);
        sample();
        check("lock_first_grant", 64'(grant_id), 64'd2);
        check("lock_first_ready", 64'(req_ready), 64'b0100);
        check("lock_before", {63'd0, lock_active}, 64'd0);
        next_cycle();
        drive(2, 1'b0, 1'b0, 32'h0);
        sample();
        check("lock_gap_active", {63'd0, lock_active}, 64'd1);
        check("lock_gap_grant_valid", {63'd0, grant_valid}, 64'd0);
        check("lock_gap_ready", 64'(req_ready), 64'd0);
        next_cycle();
        drive(2, 1'b1, 1'b0, 32'h21);
        sample();
        check("lock_b2_active", {63'd0, lock_active}, 64'd1);
        check("lock_b2_ready", 64'(req_ready), 64'b0100);
        next_cycle();
        drive(2, 1'b1, 1'b1, 32'h22);
        sample();
        check("lock_b3_active", {63'd0, lock_active}, 64'd1);
        check("lock_b3_ready", 64'(req_ready), 64'b0100);
        next_cycle();
        drive(2, 1'b0, 1'b0, 32'h0);
        sample();
        check("lock_release", {63'd0, lock_active}, 64'd0);
        check("lock_next_grant", 64'(grant_id), 64'd3);
        check("lock_next_ready", 64'(req_ready), 64'b1000);
        next_cycle();
        drive(3, 1'b0, 1'b0, 32'h0);
        wait_empty("lock_drain");
        next_cycle();

        // Full backpressure: producer 0 streams ten single-beat messages
        get_ready = 1'b0;
        for (int j = 0; j < 10; j++) sb_q.push_back(32'h100 + 32'(j));
        for (int j = 0; j < 8; j++) begin
            drive(0, 1'b1, 1'b1, 32'h100 + 32'(j));
            sample();
            check("full_fill_count", 64'(count), 64'(j));
            check("full_fill_ready", 64'(req_ready), 64'b0001);
            next_cycle();
        end
        drive(0, 1'b1, 1'b1, 32'h108);
        get_ready = 1'b1;
        sample();
        check("full_count", 64'(count), 64'd8);
        check("full_flag", {63'd0, full}, 64'd1);
        check("full_ready", 64'(req_ready), 64'd0);
        check("full_grant_valid", {63'd0, grant_valid}, 64'd1);
        next_cycle();
        get_ready = 1'b0;
        sample();
        check("full_after_pop_count", 64'(count), 64'd7);
        check("full_after_pop_ready", 64'(req_ready), 64'b0001);
        next_cycle();
        drive(0, 1'b1, 1'b1, 32'h109);
        get_ready = 1'b1;
        sample();
        check("full_refill_count", 64'(count), 64'd8);
        check("full_refill_ready", 64'(req_ready), 64'd0);
        next_cycle();
        sample();
        check("full_pushpop_count", 64'(count), 64'd7);
        check("full_pushpop_ready", 64'(req_ready), 64'b0001);
        next_cycle();
        drive(0, 1'b0, 1'b0, 32'h0);
        wait_empty("full_drain");
        next_cycle();

        // Simultaneous push/pop at count=4 across pointer wrap
        get_ready = 1'b0;
        for (int j = 0; j < 24; j++) sb_q.push_back(32'h200 + 32'(j));
        for (int j = 0; j < 4; j++) begin
            drive(1, 1'b1, 1'b1, 32'h200 + 32'(j));
            sample();
            next_cycle();
        end
        get_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            drive(1, 1'b1, 1'b1, 32'h204 + 32'(j));
            sample();
            check("wrap_count", 64'(count), 64'd4);
            check("wrap_ready", 64'(req_ready), 64'b0010);
            next_cycle();
        end
        drive(1, 1'b0, 1'b0, 32'h0);
        wait_empty("wrap_drain");
        next_cycle();

        // Reset mid-lock with count=3 (rr_ptr=2 before reset)
        get_ready = 1'b0;
        drive(1, 1'b1, 1'b1, 32'h300);
        sample();
        next_cycle();
        drive(1, 1'b1, 1'b1, 32'h301);
        sample();
        next_cycle();
        drive(1, 1'b0, 1'b0, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h320);
        sample();
        check("mid_grant", 64'(grant_id), 64'd2);
        next_cycle();
        drive(2, 1'b0, 1'b0, 32'h0);
        sample();
        check("mid_pre_count", 64'(count), 64'd3);
        check("mid_pre_lock", {63'd0, lock_active}, 64'd1);
        next_cycle();
        rst = 1'b1;
        sample();
        next_cycle();
        rst = 1'b0;
        sample();
        check("mid_post_count", 64'(count), 64'd0);
        check("mid_post_empty", {63'd0, empty}, 64'd1);
        check("mid_post_lock", {63'd0, lock_active}, 64'd0);
        check("mid_post_get_valid", {63'd0, get_valid}, 64'd0);
        check("mid_post_get_data", 64'(get_data), 64'd0);
        next_cycle();
        sb_q.push_back(32'h310); sb_q.push_back(32'h311); sb_q.push_back(32'h330);
        get_ready = 1'b1;
        drive(1, 1'b1, 1'b0, 32'h310);
        drive(3, 1'b1, 1'b1, 32'h330);
        sample();
        check("mid_new_grant_rr0", 64'(grant_id), 64'd1);
        check("mid_new_ready", 64'(req_ready), 64'b0010);
        check("mid_new_lock", {63'd0, lock_active}, 64'd0);
        next_cycle();
        drive(1, 1'b1, 1'b1, 32'h311);
        sample();
        check("mid_new_b2_lock", {63'd0, lock_active}, 64'd1);
        check("mid_new_b2_grant", 64'(grant_id), 64'd1);
        next_cycle();
        drive(1, 1'b0, 1'b0, 32'h0);
        sample();
        check("mid_next_grant", 64'(grant_id), 64'd3);
        check("mid_next_lock", {63'd0, lock_active}, 64'd0);
        next_cycle();
        drive(3, 1'b0, 1'b0, 32'h0);
        wait_empty("mid_drain");

        check("sb_all_popped", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
